debouncer_multi: RTL



---
 rtl/debouncer_multi.sv | 100 ++++++++++
 1 files changed

// File: rtl/debouncer_multi.sv
// -----------------------------------------------------------------------------
// debouncer_multi
//   Multi-channel key debouncer. Each channel synchronises its raw key level,
//   normalises it so that 1 means "pressed", and accepts a level change only
//   after it has been seen on GLITCH_TIME_CLK consecutive clock edges. Any
//   sample equal to the current debounced state restarts the count from zero.
//   An accepted change updates the debounced level and fires a one-cycle press
//   or release strobe on the same edge.
//
// Ports
//   clk_i               system clock, all logic on the rising edge
//   rst_i               synchronous, active-high reset
//   key_i               raw asynchronous key levels, one bit per channel
//   key_state_o         debounced level per channel, 1 = pressed
//   key_pressed_stb_o   one-cycle strobe when a press is accepted
//   key_released_stb_o  one-cycle strobe when a release is accepted
// -----------------------------------------------------------------------------
module debouncer_multi #(
  parameter int CHANNELS       = 4,
  parameter int CLK_FREQ_MHZ   = 20,
  parameter int GLITCH_TIME_NS = 200,
  parameter int ACTIVE_LOW     = 1,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] key_i,
  output logic [CHANNELS-1:0] key_state_o,
  output logic [CHANNELS-1:0] key_pressed_stb_o,
  output logic [CHANNELS-1:0] key_released_stb_o
);

  localparam int GLITCH_TIME_CLK = GLITCH_TIME_NS * CLK_FREQ_MHZ / 1000;
  // Guarded so the width stays legal while the elaboration error below reports
  // an unusable glitch time.
  localparam int CNT_W = (GLITCH_TIME_CLK < 1) ? 1 : $clog2(GLITCH_TIME_CLK + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GLITCH_TIME_CLK - 1);
  // Physical level of a released key; the synchroniser starts from it so that
  // leaving reset never looks like a key edge.
  localparam logic IDLE_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  if (GLITCH_TIME_CLK < 1) begin : g_bad_glitch
    $error("debouncer_multi: GLITCH_TIME_NS * CLK_FREQ_MHZ / 1000 must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debouncer_multi: SYNC_STAGES must be >= 2");
  end
  if (CHANNELS < 1) begin : g_bad_chan
    $error("debouncer_multi: CHANNELS must be >= 1");
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_state;
    logic                   r_press_stb;
    logic                   r_release_stb;
    logic                   w_p;

    // Synchroniser: only r_sync[0] ever samples the asynchronous key_i bit.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_sync <= {SYNC_STAGES{IDLE_LVL}};
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], key_i[ch]};
      end
    end

    assign w_p = (ACTIVE_LOW != 0) ? ~r_sync[SYNC_STAGES-1] : r_sync[SYNC_STAGES-1];

    // Stability counter and debounced state
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_cnt         <= '0;
        r_state       <= 1'b0;
        r_press_stb   <= 1'b0;
        r_release_stb <= 1'b0;
      end else begin
        r_press_stb   <= 1'b0;
        r_release_stb <= 1'b0;
        if (w_p == r_state) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          // GLITCH_TIME_CLK consecutive differing samples: accept the change.
          r_cnt         <= '0;
          r_state       <= w_p;
          r_press_stb   <= w_p;
          r_release_stb <= ~w_p;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end

    assign key_state_o[ch]        = r_state;
    assign key_pressed_stb_o[ch]  = r_press_stb;
    assign key_released_stb_o[ch] = r_release_stb;
  end

endmodule
